// File: rtl/outport_arbiter.sv
// Output-port arbiter: round-robin selection among five input switches
// into a single registered output slot with back-pressure and a flit counter.
`timescale 1ns/1ps

module outport_arbiter #(
    parameter int DATA_WIDTH = 288
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [4:0][DATA_WIDTH-1:0] req_data,
    input  logic [4:0]                 req_valid,
    output logic [4:0]                 clear,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       data_valid,
    input  logic                       out_busy,
    output logic [31:0]                flit_count
);

    logic [2:0] rr_ptr;
    logic [4:0] eligible;
    logic       transfer;
    logic       slot_free;
    logic       grant;
    logic [2:0] grant_idx;
    logic [2:0] next_ptr;
    logic [3:0] cand_sum;
    logic [2:0] cand;

    // A source whose clear is high still shows valid this cycle; mask it so
    // the same flit is never granted twice.
    always_comb begin
        eligible  = req_valid & ~clear;
        transfer  = data_valid & ~out_busy;
        slot_free = ~data_valid | ~out_busy;
        grant     = 1'b0;
        grant_idx = 3'd0;
        cand_sum  = 4'd0;
        cand      = 3'd0;
        for (int k = 0; k < 5; k++) begin
            cand_sum = {1'b0, rr_ptr} + 4'(k);
            cand     = (cand_sum >= 4'd5) ? 3'(cand_sum - 4'd5) : cand_sum[2:0];
            if (!grant && slot_free && eligible[cand]) begin
                grant     = 1'b1;
                grant_idx = cand;
            end
        end
        next_ptr = (grant_idx == 3'd4) ? 3'd0 : grant_idx + 3'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            clear      <= 5'b0;
            rr_ptr     <= 3'd0;
            flit_count <= 32'd0;
        end else begin
            if (transfer) begin
                flit_count <= flit_count + 32'd1;
            end
            if (grant) begin
                data_out   <= req_data[grant_idx];
                data_valid <= 1'b1;
                clear      <= 5'b00001 << grant_idx;
                rr_ptr     <= next_ptr;
            end else begin
                clear <= 5'b0;
                if (transfer) begin
                    data_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_outport_arbiter.sv
// Scoreboard bench for outport_arbiter: a reference model predicts grants and
// pushes expected flits; a negedge monitor pops and compares DUT outputs.
`timescale 1ns/1ps

module tb_outport_arbiter;
    localparam int DW = 288;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [4:0][DW-1:0] req_data = '0;
    logic [4:0]         req_valid = '0;
    logic [4:0]         clear;
    logic [DW-1:0]      data_out;
    logic               data_valid;
    logic               out_busy = 1'b0;
    logic [31:0]        flit_count;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic          m_valid = 1'b0;
    logic [4:0]    m_clear = '0;
    int            m_ptr   = 0;
    logic [31:0]   m_count = '0;
    logic [DW-1:0] exp_q[$];

    outport_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_data   (req_data),
        .req_valid  (req_valid),
        .clear      (clear),
        .data_out   (data_out),
        .data_valid (data_valid),
        .out_busy   (out_busy),
        .flit_count (flit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] v;
        v = '0;
        for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    // Advance the model by one edge using the inputs the DUT just sampled.
    task automatic model_step();
        logic       xfer;
        logic [4:0] elig;
        int         g;
        int         idx;
        xfer = m_valid && !out_busy;
        if (xfer) m_count = m_count + 32'd1;
        elig = req_valid & ~m_clear;
        g = -1;
        if (!m_valid || xfer) begin
            for (int k = 0; k < 5; k++) begin
                idx = (m_ptr + k) % 5;
                if (g < 0 && elig[idx]) g = idx;
            end
        end
        if (g >= 0) begin
            exp_q.push_back(req_data[g]);
            m_valid = 1'b1;
            m_clear = 5'b00001 << g;
            m_ptr   = (g + 1) % 5;
        end else begin
            m_clear = '0;
            if (xfer) m_valid = 1'b0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_clear", {27'd0, clear}, 32'd0);
        chk("rst_flit_count", flit_count, 32'd0);
        chk_data("rst_data_out", data_out, '0);
        req_valid = '0;
        out_busy  = 1'b0;
        m_valid = 1'b0;
        m_clear = '0;
        m_ptr   = 0;
        m_count = '0;
        exp_q.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("clear", {27'd0, clear}, {27'd0, m_clear});
            chk("data_valid", {31'd0, data_valid}, {31'd0, m_valid});
            chk("flit_count", flit_count, m_count);
            if (data_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL data_out: got flit %h expected no flit", data_out);
                end else begin
                    chk_data("data_out", data_out, exp_q[0]);
                    if (!out_busy) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] flit_a, flit_b, flit_s2;
        logic [4:0]    exp_clr;

        #2;
        do_reset();

        // single request after reset
        flit_a = rnd();
        req_data[0] = flit_a;
        req_valid = 5'b00001;
        cycle();
        chk("single_valid", {31'd0, data_valid}, 32'd1);
        chk_data("single_data", data_out, flit_a);
        chk("single_clear", {27'd0, clear}, 32'h01);
        req_valid = '0;
        cycle();
        chk("single_clear_gone", {27'd0, clear}, 32'd0);
        chk("single_count", flit_count, 32'd1);

        // all five sources continuously valid
        @(posedge clk); #1;
        do_reset();
        for (int i = 0; i < 5; i++) req_data[i] = rnd();
        req_valid = 5'b11111;
        for (int k = 1; k <= 11; k++) begin
            cycle();
            exp_clr = 5'b00001 << ((k - 1) % 5);
            chk("rr_order", {27'd0, clear}, {27'd0, exp_clr});
            for (int i = 0; i < 5; i++) if (m_clear[i]) req_data[i] = rnd();
        end
        chk("rr_count10", flit_count, 32'd10);

        // back-pressure holds flit B, then transfer plus grant in one cycle
        req_valid = '0;
        @(posedge clk); #1;
        do_reset();
        flit_b = rnd();
        req_data[4] = flit_b;
        req_valid = 5'b10000;
        cycle();
        flit_s2 = rnd();
        req_data[2] = flit_s2;
        req_data[3] = rnd();
        req_valid = 5'b01100;
        out_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk_data("bp_hold_data", data_out, flit_b);
            chk("bp_hold_clear", {27'd0, clear}, 32'd0);
        end
        out_busy = 1'b0;
        cycle();
        chk("bp_grant2_clear", {27'd0, clear}, 32'h04);
        chk_data("bp_grant2_data", data_out, flit_s2);
        chk("bp_count", flit_count, 32'd1);

        // clear mask: source 1 keeps valid through its clear cycle
        @(posedge clk); #1;
        do_reset();
        req_data[1] = rnd();
        req_valid = 5'b00010;
        cycle();
        chk("mask_first_clear", {27'd0, clear}, 32'h02);
        cycle();
        chk("mask_no_regrant", {27'd0, clear}, 32'd0);
        chk("mask_no_dup", {31'd0, data_valid}, 32'd0);
        req_valid = '0;
        cycle();
        chk("mask_count", flit_count, 32'd1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 5; i++) begin
                if (m_clear[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    req_data[i]  = rnd();
                end else if (!req_valid[i]) begin
                    req_data[i] = rnd();
                    if ($urandom_range(0, 2) == 0) req_valid[i] = 1'b1;
                end
            end
            out_busy = ($urandom_range(0, 3) == 0);
            cycle();
        end

        // reset while a flit is held under back-pressure
        out_busy = 1'b1;
        req_valid = 5'b00001;
        req_data[0] = rnd();
        cycle();
        req_valid = '0;
        cycle();
        chk("midrst_pre_valid", {31'd0, data_valid}, 32'd1);
        do_reset();
        req_data[1] = rnd();
        req_data[3] = rnd();
        req_data[4] = rnd();
        req_valid = 5'b11010;
        cycle();
        chk("midrst_first_grant", {27'd0, clear}, 32'h02);
        req_valid = '0;
        cycle();
        cycle();

        // counter wrap
        @(posedge clk); #1;
        do_reset();
        req_data[0] = rnd();
        req_valid = 5'b00001;
        cycle();
        req_valid = '0;
        force dut.flit_count = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        #1;
        release dut.flit_count;
        cycle();
        chk("wrap_count", flit_count, 32'd0);
        cycle();

        #20;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
